median_filter_ctrl: RTL
=======================

MEDIAN_FILTER_CTRL -- requirements
Module: median_filter_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 64, image row count.
REQ-002 SHALL have parameter COLS, default 20, image column count.
REQ-003 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-004 SHALL have parameter AW, default 11, address width; ROWS*COLS SHALL be no greater than 2**AW.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  begin one frame pass; sampled only in IDLE.
REQ-008 abort  in  1  terminate the pass at once.
REQ-009 pause  in  1  suspend source reads; in-flight results still written.
REQ-010 busy  out  1  high in READ and DRAIN.
REQ-011 done  out  1  one-cycle pulse on the frame's final write.
REQ-012 src_rd_en  out  1  source memory read strobe; read data returns 1 cycle later.
REQ-013 src_addr  out  AW  source read address, raster order (row*COLS+col).
REQ-014 src_rd_data  in  PIX_W  source read data.
REQ-015 flt_in_valid  out  1  pixel valid to the median pipeline.
REQ-016 flt_in_data  out  PIX_W  pixel to the median pipeline.
REQ-017 flt_out_valid  in  1  median pipeline result valid.
REQ-018 flt_out_data  in  PIX_W  median pipeline result.
REQ-019 dst_wr_en  out  1  destination memory write strobe.
REQ-020 dst_addr  out  AW  destination write address, raster order.
REQ-021 dst_wr_data  out  PIX_W  destination write data.

Function
REQ-022 FSM SHALL have states IDLE, READ, DRAIN, DONE.
REQ-023 IDLE->READ on start; rd_cnt and wr_cnt SHALL be cleared on that transition.
REQ-024 In READ, src_rd_en SHALL be high each cycle that pause is low; src_addr=rd_cnt; rd_cnt SHALL increment per issued read.
REQ-025 flt_in_valid/flt_in_data SHALL be src_rd_en/src_rd_data delayed so that they align with the 1-cycle read latency.
REQ-026 READ->DRAIN SHALL occur after read ROWS*COLS-1 issues.
REQ-027 In READ or DRAIN, each flt_out_valid SHALL produce dst_wr_en in the same cycle, with dst_addr=wr_cnt and dst_wr_data=flt_out_data; wr_cnt SHALL then increment.
REQ-028 On the write at wr_cnt=ROWS*COLS-1, the FSM SHALL go to DONE, and done SHALL pulse in the same cycle.
REQ-029 DONE SHALL go to IDLE unconditionally after 1 cycle; start SHALL be ignored in DONE.
REQ-030 In IDLE and DONE, flt_out_valid SHALL be ignored: no dst_wr_en, no counter change.
REQ-031 abort in READ or DRAIN SHALL force IDLE next cycle with no done pulse; abort SHALL take priority over the pause, read and write actions in that cycle.
REQ-032 pause SHALL freeze rd_cnt and hold src_rd_en low; writes SHALL continue during pause.
REQ-033 A flt_out_valid after wr_cnt reaches ROWS*COLS SHALL never occur while the FSM is in DONE or IDLE (REQ-030 covers it).
REQ-034 Counters SHALL be AW bits wide and SHALL never wrap within a pass.

Reset
REQ-035 Asserting rst_n low SHALL set state=IDLE, rd_cnt=wr_cnt=0, and all outputs to 0, asynchronously.
REQ-036 Reset mid-pass SHALL discard the pass; the first start after release SHALL begin at address 0.

Configuration
REQ-037 With MEDIAN_CTRL_PERF_EN defined, the block SHALL add output cycle_cnt[31:0]: cleared on start, incremented each busy cycle, and held after done or abort.
REQ-038 Without MEDIAN_CTRL_PERF_EN, the cycle_cnt port and its counter SHALL not exist.

Structure
REQ-039 A package median_pkg SHALL hold the FSM state enum, the default ROWS/COLS/PIX_W constants and the FRAME_PIX=ROWS*COLS constant.
REQ-040 The block SHALL be a single module; the median pipeline and memories are external.

Verification
REQ-041 start with a pipeline model of latency 4 -> 1280 reads at addresses 0..1279 and 1280 writes at 0..1279; done pulses exactly once, 1284 cycles after the first read (perf on: cycle_cnt=1285).
REQ-042 pause high for 10 cycles at rd_cnt=100 -> no reads at 100..109 cycles, writes in flight complete, and the address sequence stays gap-free.
REQ-043 abort at wr_cnt=500 -> IDLE next cycle, no done pulse; a following start rereads from address 0.
REQ-044 flt_out_valid pulsed in IDLE -> no dst_wr_en; start asserted during DRAIN -> ignored.
REQ-045 rst_n low mid-READ -> all outputs 0 immediately; a pass after release completes normally.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and default geometry for the median filter frame controller.
package median_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_ROWS  = 64;
    localparam int unsigned DEF_COLS  = 20;
    localparam int unsigned DEF_PIX_W = 8;
    localparam int unsigned DEF_AW    = 11;
    localparam int unsigned FRAME_PIX = DEF_ROWS * DEF_COLS;
    localparam int unsigned CYC_W     = 32;

endpackage

// File: rtl/median_filter_ctrl.sv
// Streams one frame from source memory through an external median pipeline into
// destination memory. Optional MEDIAN_CTRL_PERF_EN adds a busy-cycle counter.
module median_filter_ctrl
    import median_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned PIX_W = DEF_PIX_W,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    output logic             busy,
    output logic             done,
    output logic             src_rd_en,
    output logic [AW-1:0]    src_addr,
    input  logic [PIX_W-1:0] src_rd_data,
    output logic             flt_in_valid,
    output logic [PIX_W-1:0] flt_in_data,
    input  logic             flt_out_valid,
    input  logic [PIX_W-1:0] flt_out_data,
    output logic             dst_wr_en,
    output logic [AW-1:0]    dst_addr,
    output logic [PIX_W-1:0] dst_wr_data
`ifdef MEDIAN_CTRL_PERF_EN
    ,
    output logic [CYC_W-1:0] cycle_cnt
`endif
);

    localparam int unsigned   FRAME    = ROWS * COLS;
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
    logic            flt_vld_q;
    logic            in_pass;
    logic            rd_fire;
    logic            wr_fire;
    logic            last_rd;
    logic            last_wr;

    // Per-cycle actions; abort suppresses both read and write in its cycle.
    always_comb begin
        in_pass = (state_q == ST_READ) || (state_q == ST_DRAIN);
        rd_fire = (state_q == ST_READ) && !pause && !abort;
        wr_fire = in_pass && flt_out_valid && !abort;
        last_rd = rd_fire && (rd_cnt_q == LAST_IDX);
        last_wr = wr_fire && (wr_cnt_q == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            flt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            flt_vld_q <= rd_fire;
        end
    end

    // Counters hold at the last index so they never wrap even when FRAME == 2**AW.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_READ;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (last_wr) begin
                        state_d = ST_DONE;
                    end else if (last_rd) begin
                        state_d = ST_DRAIN;
                    end
                    if (rd_fire && !last_rd) begin
                        rd_cnt_d = rd_cnt_q + AW'(1);
                    end
                    if (wr_fire && !last_wr) begin
                        wr_cnt_d = wr_cnt_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (last_wr) begin
                        state_d = ST_DONE;
                    end
                    if (wr_fire && !last_wr) begin
                        wr_cnt_d = wr_cnt_q + AW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes track the current cycle so the write lands with the pipeline result.
    assign busy         = in_pass;
    assign done         = last_wr;
    assign src_rd_en    = rd_fire;
    assign src_addr     = rd_cnt_q;
    assign flt_in_valid = flt_vld_q;
    assign flt_in_data  = flt_vld_q ? src_rd_data : '0;
    assign dst_wr_en    = wr_fire;
    assign dst_addr     = wr_cnt_q;
    assign dst_wr_data  = wr_fire ? flt_out_data : '0;

`ifdef MEDIAN_CTRL_PERF_EN
    logic [CYC_W-1:0] cyc_q;

    // Counts READ/DRAIN cycles of the latest pass; holds once the pass ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            cyc_q <= '0;
        end else if (in_pass) begin
            cyc_q <= cyc_q + CYC_W'(1);
        end
    end

    assign cycle_cnt = cyc_q;
`endif

endmodule
